// File: rtl/riscv_mem_port_arbiter_if.sv
// Bundle of client request/response ports, the shared memory port and status outputs.
// The arbiter takes the slave view; whoever drives the clients and the memory takes the master view.
interface riscv_mem_port_arbiter_if #(
  parameter int REQ_W  = 67,
  parameter int RESP_W = 35,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [REQ_W-1:0]  imemreq0_msg;
  logic              imemreq0_val;
  logic              imemreq0_rdy;
  logic [REQ_W-1:0]  imemreq1_msg;
  logic              imemreq1_val;
  logic              imemreq1_rdy;
  logic [REQ_W-1:0]  dmemreq_msg;
  logic              dmemreq_val;
  logic              dmemreq_rdy;

  logic [RESP_W-1:0] imemresp0_msg;
  logic              imemresp0_val;
  logic [RESP_W-1:0] imemresp1_msg;
  logic              imemresp1_val;
  logic [RESP_W-1:0] dmemresp_msg;
  logic              dmemresp_val;

  logic [REQ_W-1:0]  memreq_msg;
  logic              memreq_val;
  logic              memreq_rdy;
  logic [RESP_W-1:0] memresp_msg;
  logic              memresp_val;

  logic [CNT_W-1:0]  outstanding;
  logic              resp_err;

  modport slave (
    input  imemreq0_msg, imemreq0_val, imemreq1_msg, imemreq1_val,
    input  dmemreq_msg, dmemreq_val, memreq_rdy, memresp_msg, memresp_val,
    output imemreq0_rdy, imemreq1_rdy, dmemreq_rdy,
    output imemresp0_msg, imemresp0_val, imemresp1_msg, imemresp1_val,
    output dmemresp_msg, dmemresp_val, memreq_msg, memreq_val,
    output outstanding, resp_err
  );

  modport master (
    output imemreq0_msg, imemreq0_val, imemreq1_msg, imemreq1_val,
    output dmemreq_msg, dmemreq_val, memreq_rdy, memresp_msg, memresp_val,
    input  imemreq0_rdy, imemreq1_rdy, dmemreq_rdy,
    input  imemresp0_msg, imemresp0_val, imemresp1_msg, imemresp1_val,
    input  dmemresp_msg, dmemresp_val, memreq_msg, memreq_val,
    input  outstanding, resp_err
  );
endinterface

// File: rtl/riscv_mem_port_arbiter.sv
// Shares one in-order memory port between imem slot 0, imem slot 1 and dmem.
// Accepted request sources are queued in a tag FIFO so responses steer back to their issuer.
module riscv_mem_port_arbiter #(
  parameter int REQ_W  = 67,
  parameter int RESP_W = 35,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_mem_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SRC_IMEM0 = 2'd0,
    SRC_IMEM1 = 2'd1,
    SRC_DMEM  = 2'd2
  } src_e;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             rr_q, rr_d;
  logic             err_q, err_d;
  src_e             tag_q [DEPTH];
  src_e             tag_d [DEPTH];

  src_e             gnt;
  src_e             head_src;
  logic             any_val;
  logic             space;
  logic             req_val;
  logic             accept;
  logic             pop;

  always_comb begin
    any_val = bus.imemreq0_val | bus.imemreq1_val | bus.dmemreq_val;

    // rr_q == 0 prefers imem0; the other slot only wins when the preferred one is idle.
    if (bus.dmemreq_val)       gnt = SRC_DMEM;
    else if (!rr_q)            gnt = bus.imemreq0_val ? SRC_IMEM0 : SRC_IMEM1;
    else                       gnt = bus.imemreq1_val ? SRC_IMEM1 : SRC_IMEM0;

    space    = (count_q != CNT_W'(DEPTH)) | bus.memresp_val;
    req_val  = ~reset & space & any_val;
    accept   = req_val & bus.memreq_rdy;
    pop      = ~reset & bus.memresp_val & (count_q != '0);
    head_src = tag_q[head_q];

    case (gnt)
      SRC_IMEM0: bus.memreq_msg = bus.imemreq0_msg;
      SRC_IMEM1: bus.memreq_msg = bus.imemreq1_msg;
      default:   bus.memreq_msg = bus.dmemreq_msg;
    endcase
    bus.memreq_val   = req_val;
    bus.imemreq0_rdy = accept & (gnt == SRC_IMEM0);
    bus.imemreq1_rdy = accept & (gnt == SRC_IMEM1);
    bus.dmemreq_rdy  = accept & (gnt == SRC_DMEM);

    bus.imemresp0_msg = bus.memresp_msg;
    bus.imemresp1_msg = bus.memresp_msg;
    bus.dmemresp_msg  = bus.memresp_msg;
    bus.imemresp0_val = pop & (head_src == SRC_IMEM0);
    bus.imemresp1_val = pop & (head_src == SRC_IMEM1);
    bus.dmemresp_val  = pop & (head_src == SRC_DMEM);

    bus.outstanding = count_q;
    bus.resp_err    = err_q;
  end

  always_comb begin
    tag_d   = tag_q;
    tail_d  = tail_q;
    head_d  = head_q;
    count_d = count_q;
    rr_d    = rr_q;
    err_d   = err_q | (bus.memresp_val & (count_q == '0));

    if (accept) begin
      tag_d[tail_q] = gnt;
      tail_d        = tail_q + 1'b1;
      if (gnt != SRC_DMEM) rr_d = (gnt == SRC_IMEM0);
    end
    if (pop) head_d = head_q + 1'b1;

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= SRC_IMEM0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
    end
  end
endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Directed bench for riscv_mem_port_arbiter: grants, ordering, full FIFO, backpressure, error/reset.
module tb_riscv_mem_port_arbiter;
  localparam int REQ_W  = 67;
  localparam int RESP_W = 35;
  localparam int DEPTH  = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  riscv_mem_port_arbiter_if #(.REQ_W(REQ_W), .RESP_W(RESP_W), .DEPTH(DEPTH)) bus ();

  riscv_mem_port_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rdy_v, rsp_v;
  assign rdy_v = {bus.imemreq0_rdy, bus.imemreq1_rdy, bus.dmemreq_rdy};
  assign rsp_v = {bus.imemresp0_val, bus.imemresp1_val, bus.dmemresp_val};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input logic [31:0] addr);
    return {1'b0, addr, 2'b00, 32'h0};
  endfunction

  function automatic logic [2:0] oh(input int s);
    logic [2:0] v;
    v = 3'b100;
    return v >> s;
  endfunction

  function automatic logic [31:0] addr_of(input int s);
    case (s)
      0:       return 32'h100;
      1:       return 32'h104;
      default: return 32'h800;
    endcase
  endfunction

  function automatic logic [31:0] data_of(input int s);
    case (s)
      0:       return bus.imemresp0_msg[31:0];
      1:       return bus.imemresp1_msg[31:0];
      default: return bus.dmemresp_msg[31:0];
    endcase
  endfunction

  task automatic set_req(input logic v0, input logic v1, input logic vd);
    bus.imemreq0_val = v0;
    bus.imemreq1_val = v1;
    bus.dmemreq_val  = vd;
  endtask

  task automatic set_resp(input logic v, input logic [31:0] d);
    bus.memresp_val = v;
    bus.memresp_msg = {1'b0, 2'b00, d};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t2_src [6] = '{2, 2, 2, 0, 1, 0};
  int t3_src [3] = '{1, 2, 0};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.imemreq0_msg = mk_req(32'h100);
    bus.imemreq1_msg = mk_req(32'h104);
    bus.dmemreq_msg  = mk_req(32'h800);
    bus.memreq_rdy   = 1'b1;
    set_req(1'b0, 1'b0, 1'b1);
    set_resp(1'b0, 32'h0);
    reset = 1'b1;

    #12;
    check("rst_out",  32'(bus.outstanding), 32'd0);
    check("rst_err",  32'(bus.resp_err), 32'd0);
    check("rst_mval", 32'(bus.memreq_val), 32'd0);
    check("rst_rdy",  32'(rdy_v), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set_req(1'b0, 1'b0, 1'b0);

    // single fetch
    @(negedge clk);
    bus.imemreq0_msg = mk_req(32'h200);
    set_req(1'b1, 1'b0, 1'b0);
    #1;
    check("t1_addr", bus.memreq_msg[65:34], 32'h200);
    check("t1_rdy",  32'(rdy_v), 32'(3'b100));
    tick();
    check("t1_out1", 32'(bus.outstanding), 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0);
    bus.imemreq0_msg = mk_req(32'h100);
    set_resp(1'b1, 32'hDEADBEEF);
    #1;
    check("t1_rval",  32'(rsp_v), 32'(3'b100));
    check("t1_rdata", bus.imemresp0_msg[31:0], 32'hDEADBEEF);
    tick();
    check("t1_out0", 32'(bus.outstanding), 32'd0);

    // contention, starting from rr_ptr = imem0
    @(negedge clk);
    set_resp(1'b0, 32'h0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_req(1'b1, 1'b1, i < 3);
      set_resp(i > 0, 32'(i));
      #1;
      check("t2_gnt",  32'(rdy_v), 32'(oh(t2_src[i])));
      check("t2_addr", bus.memreq_msg[65:34], addr_of(t2_src[i]));
      if (i > 0) check("t2_rsp", 32'(rsp_v), 32'(oh(t2_src[i-1])));
      tick();
    end
    check("t2_out1", 32'(bus.outstanding), 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0);
    set_resp(1'b1, 32'h0);
    #1;
    check("t2_rsp_last", 32'(rsp_v), 32'(oh(0)));
    tick();
    check("t2_out0", 32'(bus.outstanding), 32'd0);

    // ordering of responses
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_resp(1'b0, 32'h0);
      set_req(t3_src[i] == 0, t3_src[i] == 1, t3_src[i] == 2);
      #1;
      check("t3_gnt", 32'(rdy_v), 32'(oh(t3_src[i])));
      tick();
    end
    check("t3_out3", 32'(bus.outstanding), 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_req(1'b0, 1'b0, 1'b0);
      set_resp(1'b1, 32'(i + 1));
      #1;
      check("t3_rsp",  32'(rsp_v), 32'(oh(t3_src[i])));
      check("t3_data", data_of(t3_src[i]), 32'(i + 1));
      tick();
    end
    check("t3_out0", 32'(bus.outstanding), 32'd0);

    // full FIFO, then simultaneous pop and push
    @(negedge clk);
    set_resp(1'b0, 32'h0);
    set_req(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("t4_out4", 32'(bus.outstanding), 32'd4);
    @(negedge clk);
    #1;
    check("t4_full_mval", 32'(bus.memreq_val), 32'd0);
    check("t4_full_rdy",  32'(rdy_v), 32'd0);
    @(negedge clk);
    set_resp(1'b1, 32'h55);
    #1;
    check("t4_pp_mval", 32'(bus.memreq_val), 32'd1);
    check("t4_pp_rdy",  32'(rdy_v), 32'(oh(2)));
    check("t4_pp_rsp",  32'(rsp_v), 32'(oh(2)));
    tick();
    check("t4_pp_out", 32'(bus.outstanding), 32'd4);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("t4_drain", 32'(bus.outstanding), 32'd0);

    // backpressure; rr_ptr currently prefers imem1
    @(negedge clk);
    set_resp(1'b0, 32'h0);
    bus.memreq_rdy = 1'b0;
    set_req(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_mval", 32'(bus.memreq_val), 32'd1);
      check("t5_rdy",  32'(rdy_v), 32'd0);
      tick();
      check("t5_out", 32'(bus.outstanding), 32'd0);
      @(negedge clk);
    end
    bus.memreq_rdy = 1'b1;
    set_req(1'b1, 1'b1, 1'b0);
    #1;
    check("t5_rr", 32'(rdy_v), 32'(oh(1)));
    tick();
    check("t5_out1", 32'(bus.outstanding), 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0);
    set_resp(1'b1, 32'h7);
    #1;
    check("t5_rsp", 32'(rsp_v), 32'(oh(1)));
    tick();
    check("t5_out0", 32'(bus.outstanding), 32'd0);

    // stray response, then async reset with two outstanding
    @(negedge clk);
    #1;
    check("t6_norsp", 32'(rsp_v), 32'd0);
    tick();
    check("t6_err", 32'(bus.resp_err), 32'd1);
    @(negedge clk);
    set_resp(1'b0, 32'h0);
    set_req(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    set_req(1'b0, 1'b0, 1'b0);
    check("t6_out2",    32'(bus.outstanding), 32'd2);
    check("t6_err_hold", 32'(bus.resp_err), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_out", 32'(bus.outstanding), 32'd0);
    check("t6_rst_err", 32'(bus.resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    set_resp(1'b1, 32'h9);
    #1;
    check("t6_post_rsp", 32'(rsp_v), 32'd0);
    tick();
    check("t6_post_err", 32'(bus.resp_err), 32'd1);
    @(negedge clk);
    set_resp(1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/riscv_mem_port_arbiter.md
Name: riscv_mem_port_arbiter

Overview:
Shares one unified memory request/response port between the core's three memory clients: imemreq0, imemreq1 and dmemreq.
- Sits between the dual-issue core and a single-ported memory.
- Arbitrates requests each cycle and records the source of each accepted request in an in-order tag FIFO.
- Steers each in-order memory response back to the client that issued the matching request.

Parameters:
REQ_W, 67, request message width (vc mem req msg: type 1 + addr 32 + len 2 + data 32)
RESP_W, 35, response message width (type 1 + len 2 + data 32)
DEPTH, 4, maximum outstanding requests; power of two, ≥2

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imemreq0_msg  in  REQ_W  fetch-slot-0 request
imemreq0_val  in  1  fetch-slot-0 request valid
imemreq0_rdy  out  1  fetch-slot-0 request accepted
imemreq1_msg  in  REQ_W  fetch-slot-1 request
imemreq1_val  in  1  fetch-slot-1 request valid
imemreq1_rdy  out  1  fetch-slot-1 request accepted
dmemreq_msg  in  REQ_W  data request
dmemreq_val  in  1  data request valid
dmemreq_rdy  out  1  data request accepted
imemresp0_msg  out  RESP_W  response to slot 0
imemresp0_val  out  1  response valid to slot 0
imemresp1_msg  out  RESP_W  response to slot 1
imemresp1_val  out  1  response valid to slot 1
dmemresp_msg  out  RESP_W  response to data client
dmemresp_val  out  1  response valid to data client
memreq_msg  out  REQ_W  granted request to memory
memreq_val  out  1  request valid to memory
memreq_rdy  in  1  memory accepts request
memresp_msg  in  RESP_W  in-order memory response
memresp_val  in  1  memory response valid (no backpressure)
outstanding  out  clog2(DEPTH)+1  current tag-FIFO occupancy
resp_err  out  1  sticky: response arrived with no outstanding request

Behaviour:
- Reset (async, active-high) forces:
  - FIFO count, head and tail to 0
  - round-robin pointer to imem0
  - resp_err to 0
  - all *_rdy, *_val outputs and outstanding to 0
- space = (count != DEPTH) | memresp_val; a same-cycle pop frees the slot for a push.
- Grant selection (combinational):
  - dmem wins when dmemreq_val.
  - Otherwise imem0 and imem1 share by round-robin. rr_ptr names the preferred slot; the other slot wins only if the preferred one is not valid.
- memreq_val = space & (any client val); it never depends on memreq_rdy.
- memreq_msg = granted client's msg; don't-care when memreq_val=0.
- Only the granted client's rdy = memreq_rdy & space; all other client rdy outputs are 0.
- Accept = memreq_val & memreq_rdy. On accept:
  - Push the 2-bit source id (0=imem0, 1=imem1, 2=dmem) at tail; tail wraps modulo DEPTH.
  - If the winner was an imem slot, rr_ptr moves to the other slot. A dmem grant leaves rr_ptr unchanged.
- On memresp_val with count>0:
  - Route memresp_msg combinationally, same cycle, zero latency, to the client named at head; assert only that client's val.
  - Pop head; head wraps modulo DEPTH.
- On memresp_val with count==0: no client val asserted, no pop, resp_err set to 1. resp_err clears only on reset.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Both imem slots valid in the same cycle with no dmem: only the rr_ptr slot is granted. The other stays pending and is granted the next cycle if memreq_rdy and space allow.
- Reset mid-operation discards all outstanding tags; responses arriving after reset set resp_err.
- Requesters must hold msg stable while val=1 and rdy=0; the arbiter does not latch request messages.

Test Plan:
1. Single fetch: imemreq0_val=1 with addr 0x200, memreq_rdy=1 → memreq_msg carries addr 0x200, imemreq0_rdy=1, outstanding=1; memresp_val next cycle with data 0xDEADBEEF → imemresp0_val=1 with that data, outstanding=0.
2. Contention: all three valid for 3 cycles, rdy=1, rr_ptr=imem0 → grant order dmem, dmem, dmem while dmem stays valid; drop dmem → grant order imem0, imem1, imem0.
3. Ordering: accept imem1, dmem, imem0 back to back; return responses 0x1, 0x2, 0x3 → imem1 gets 0x1, dmem gets 0x2, imem0 gets 0x3; every other val stays 0.
4. Full FIFO (DEPTH=4): 4 accepts with no response → outstanding=4, memreq_val=0 and all rdy=0. Next cycle memresp_val=1 with a pending request → pop and push same cycle, outstanding stays 4.
5. Backpressure: memreq_rdy=0 for 5 cycles with dmemreq_val=1 → memreq_val=1 and dmemreq_rdy=0 throughout, outstanding unchanged, rr_ptr unchanged.
6. Error and reset: memresp_val with outstanding=0 → resp_err=1 and no client val. Assert reset asynchronously mid-cycle with 2 outstanding → outstanding=0 and resp_err=0 immediately.
